// File: rtl/counter_server_if.sv
`default_nettype none
// ============================================================================
//  Module      : counter_server_if
//  Description : Request/response bundle between the kernel clients and the
//                counters server.
//                  rx_*  : request channel (client -> server), rx_full is the
//                          backpressure back toward the clients
//                  rsp_* : registered READ response (server -> client),
//                          rsp_full is the sink's backpressure
//                master modport = client side, slave modport = server side.
//  Revision    : 1.0  initial release
// ============================================================================
interface counter_server_if #(
    parameter int IDX_W = 6,
    parameter int CTR_W = 32,
    parameter int ARG_W = 32,
    parameter int ID_W  = 8
);
    logic             rx_valid;
    logic [ID_W-1:0]  rx_srcid;
    logic [ID_W-1:0]  rx_dstid;
    logic [ARG_W-1:0] rx_arg0;
    logic [ARG_W-1:0] rx_arg1;
    logic [ARG_W-1:0] rx_arg2;
    logic             rx_full;

    logic             rsp_valid;
    logic [ID_W-1:0]  rsp_srcid;
    logic [IDX_W-1:0] rsp_idx;
    logic [CTR_W-1:0] rsp_data;
    logic             rsp_full;

    modport master (
        output rx_valid, rx_srcid, rx_dstid, rx_arg0, rx_arg1, rx_arg2,
        input  rx_full,
        input  rsp_valid, rsp_srcid, rsp_idx, rsp_data,
        output rsp_full
    );

    modport slave (
        input  rx_valid, rx_srcid, rx_dstid, rx_arg0, rx_arg1, rx_arg2,
        output rx_full,
        output rsp_valid, rsp_srcid, rsp_idx, rsp_data,
        input  rsp_full
    );
endinterface
`default_nettype wire

// File: rtl/counter_server.sv
`default_nettype none
// ============================================================================
//  Module      : counter_server
//  Description : Server end of the counters service. Requests (INC / READ /
//                CLEAR) enter a small FIFO and are applied to a counter RAM by
//                a 2-stage read-modify-write pipeline; READs produce a
//                registered response.
//  Ports       : clk, rst_n    - clock, synchronous active-low reset
//                bus (slave)   - request channel in, response channel out
//                init_done     - counter clear sweep finished
//                drop_cnt      - requests lost to overflow / init (saturating)
//                bad_cnt       - bad opcode or index requests (saturating)
//  Revision    : 1.0  initial release
// ============================================================================
module counter_server #(
    parameter int NUM_CTRS   = 64,
    parameter int IDX_W      = 6,
    parameter int CTR_W      = 32,
    parameter int ARG_W      = 32,
    parameter int ID_W       = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    counter_server_if.slave bus,
    output logic            init_done,
    output logic [15:0]     drop_cnt,
    output logic [15:0]     bad_cnt
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [0:0] c_ST_INIT = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    localparam logic [1:0] c_OP_INC   = 2'd0;
    localparam logic [1:0] c_OP_READ  = 2'd1;
    localparam logic [1:0] c_OP_CLEAR = 2'd2;

    typedef struct packed {
        logic [ID_W-1:0]  srcid;
        logic [IDX_W-1:0] idx;
        logic [1:0]       op;
        logic [CTR_W-1:0] amt;
        logic             bad;
    } req_t;

    // ---------------------------------------------------------------- FSM
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [IDX_W-1:0] r_init_idx;
    logic             w_init_we;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_ST_INIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_INIT: if (r_init_idx == IDX_W'(NUM_CTRS - 1)) w_state_nxt = c_ST_RUN;
            default:   w_state_nxt = r_state;
        endcase
    end

    logic [c_CNT_W-1:0] r_count;

    always_comb begin
        w_init_we   = (r_state == c_ST_INIT);
        init_done   = (r_state == c_ST_RUN);
        // Threshold leaves two slots for requests already in the clients' tx registers.
        bus.rx_full = w_init_we || (r_count >= c_CNT_W'(FIFO_DEPTH - 2));
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                  r_init_idx <= '0;
        else if (r_state == c_ST_INIT) r_init_idx <= r_init_idx + IDX_W'(1);
    end

    // --------------------------------------------------------------- FIFO
    req_t               r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    req_t               w_in_req;
    req_t               w_head;
    logic               w_stall;
    logic               w_pop;
    logic               w_push_ok;
    logic               w_drop;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    always_comb begin
        w_in_req.srcid = bus.rx_srcid;
        w_in_req.idx   = bus.rx_arg0[IDX_W-1:0];
        w_in_req.op    = bus.rx_arg2[1:0];
        w_in_req.amt   = bus.rx_arg1[CTR_W-1:0];
        w_in_req.bad   = (bus.rx_arg0 >= ARG_W'(NUM_CTRS)) || (bus.rx_arg2 > ARG_W'(2));
    end

    assign w_head    = r_fifo[r_rd_ptr];
    assign w_pop     = (r_state == c_ST_RUN) && !w_stall && (r_count != '0);
    // A pop in the same cycle frees a slot, so a push at full still lands.
    assign w_push_ok = bus.rx_valid && (r_state == c_ST_RUN) &&
                       ((r_count < c_CNT_W'(FIFO_DEPTH)) || w_pop);
    assign w_drop    = bus.rx_valid && !w_push_ok;

    always_ff @(posedge clk) begin
        if (w_push_ok) r_fifo[r_wr_ptr] <= w_in_req;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)     r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + c_CNT_W'(w_push_ok) - c_CNT_W'(w_pop);
        end
    end

    // ----------------------------------------------------- RAM + pipeline
    logic [CTR_W-1:0] r_mem [NUM_CTRS];
    logic [CTR_W-1:0] r_rd_data;
    logic             r_s1_valid;
    req_t             r_s1;
    logic             r_s2_valid;
    req_t             r_s2;
    logic [CTR_W-1:0] r_s2_opnd;
    logic [CTR_W-1:0] w_s2_new;
    logic             w_s2_we;
    logic             w_s2_rsp;
    logic [CTR_W-1:0] w_s1_opnd;
    logic             w_we;
    logic [IDX_W-1:0] w_waddr;
    logic [CTR_W-1:0] w_wdata;

    assign w_s2_rsp = r_s2_valid && !r_s2.bad && (r_s2.op == c_OP_READ);
    assign w_stall  = w_s2_rsp && bus.rsp_full;
    assign w_s2_we  = r_s2_valid && !r_s2.bad && (r_s2.op != c_OP_READ);
    assign w_s2_new = (r_s2.op == c_OP_CLEAR) ? '0 : r_s2_opnd + r_s2.amt;

    assign w_we    = w_init_we || w_s2_we;
    assign w_waddr = w_init_we ? r_init_idx : r_s2.idx;
    assign w_wdata = w_init_we ? '0 : w_s2_new;

    // Request in S2 has not landed in the RAM yet when S1 read was issued.
    assign w_s1_opnd = (w_s2_we && (r_s2.idx == r_s1.idx)) ? w_s2_new : r_rd_data;

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
        // Write-to-read bypass covers the write that lands on the read edge.
        if (w_pop) r_rd_data <= (w_we && (w_waddr == w_head.idx)) ? w_wdata : r_mem[w_head.idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= w_pop;
            r_s2_valid <= r_s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!w_stall) begin
            if (w_pop) r_s1 <= w_head;
            r_s2      <= r_s1;
            r_s2_opnd <= w_s1_opnd;
        end
    end

    // ------------------------------------------------- response + counters
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_srcid;
    logic [IDX_W-1:0] r_rsp_idx;
    logic [CTR_W-1:0] r_rsp_data;
    logic [15:0]      r_drop_cnt;
    logic [15:0]      r_bad_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_srcid <= '0;
            r_rsp_idx   <= '0;
            r_rsp_data  <= '0;
        end else if (w_s2_rsp && !bus.rsp_full) begin
            r_rsp_valid <= 1'b1;
            r_rsp_srcid <= r_s2.srcid;
            r_rsp_idx   <= r_s2.idx;
            r_rsp_data  <= r_s2_opnd;
        end else begin
            r_rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
            r_bad_cnt  <= '0;
        end else begin
            if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
            // A bad request never stalls, so it sits in S2 for exactly one cycle.
            if (r_s2_valid && r_s2.bad && (r_bad_cnt != 16'hFFFF)) r_bad_cnt <= r_bad_cnt + 16'd1;
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_srcid = r_rsp_srcid;
    assign bus.rsp_idx   = r_rsp_idx;
    assign bus.rsp_data  = r_rsp_data;
    assign drop_cnt      = r_drop_cnt;
    assign bad_cnt       = r_bad_cnt;

endmodule
`default_nettype wire

// File: tb/tb_counter_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_server
//  Description : Directed self-checking bench for counter_server.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_counter_server;
    localparam int NUM_CTRS   = 64;
    localparam int IDX_W      = 6;
    localparam int CTR_W      = 32;
    localparam int ARG_W      = 32;
    localparam int ID_W       = 8;
    localparam int FIFO_DEPTH = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done;
    logic [15:0] drop_cnt;
    logic [15:0] bad_cnt;

    int checks = 0;
    int errors = 0;
    int rsp_seen = 0;

    logic [ID_W-1:0]  q_src  [$];
    logic [IDX_W-1:0] q_idx  [$];
    logic [CTR_W-1:0] q_data [$];

    always #5 clk = ~clk;

    counter_server_if #(.IDX_W(IDX_W), .CTR_W(CTR_W), .ARG_W(ARG_W), .ID_W(ID_W)) bus ();

    counter_server #(
        .NUM_CTRS(NUM_CTRS), .IDX_W(IDX_W), .CTR_W(CTR_W),
        .ARG_W(ARG_W), .ID_W(ID_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .init_done(init_done), .drop_cnt(drop_cnt), .bad_cnt(bad_cnt)
    );

    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            q_src.push_back(bus.rsp_srcid);
            q_idx.push_back(bus.rsp_idx);
            q_data.push_back(bus.rsp_data);
            rsp_seen++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [ID_W-1:0] s, input logic [ARG_W-1:0] idx,
                        input logic [ARG_W-1:0] amt, input logic [ARG_W-1:0] op);
        bus.rx_valid = 1'b1;
        bus.rx_srcid = s;
        bus.rx_dstid = 8'hD0;
        bus.rx_arg0  = idx;
        bus.rx_arg1  = amt;
        bus.rx_arg2  = op;
        step();
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic get_rsp(output bit ok, output logic [ID_W-1:0] s,
                           output logic [IDX_W-1:0] i, output logic [CTR_W-1:0] d);
        int n = 0;
        bus.rx_valid = 1'b0;
        ok = 1'b0; s = '0; i = '0; d = '0;
        while (q_data.size() == 0 && n < 50) begin
            step();
            n++;
        end
        if (q_data.size() != 0) begin
            ok = 1'b1;
            s = q_src.pop_front();
            i = q_idx.pop_front();
            d = q_data.pop_front();
        end
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (init_done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        bit ok;
        logic [ID_W-1:0] s; logic [IDX_W-1:0] i; logic [CTR_W-1:0] d;
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (bus.rx_full !== 1'b1) begin errors++; $display("FAIL reset_rx_full: got %0b want 1", bus.rx_full); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b want 0", bus.rsp_valid); end
        checks++; if ({bus.rsp_srcid, bus.rsp_idx, bus.rsp_data} !== '0) begin errors++; $display("FAIL reset_rsp_fields: got %h/%h/%h want 0", bus.rsp_srcid, bus.rsp_idx, bus.rsp_data); end
        checks++; if (init_done !== 1'b0 || drop_cnt !== 16'd0 || bad_cnt !== 16'd0) begin errors++; $display("FAIL reset_status: got init_done=%0b drop=%0d bad=%0d want 0/0/0", init_done, drop_cnt, bad_cnt); end
        rst_n = 1'b1;
        wait_init(n);
        checks++; if (n != NUM_CTRS) begin errors++; $display("FAIL init_cycles: got %0d want %0d", n, NUM_CTRS); end
        checks++; if (bus.rx_full !== 1'b0) begin errors++; $display("FAIL run_rx_full: got %0b want 0", bus.rx_full); end
        send(8'h5A, 7, 0, 1);
        get_rsp(ok, s, i, d);
        checks++; if (!ok || d !== 32'd0 || s !== 8'h5A || i !== 6'd7) begin errors++; $display("FAIL read_idx7: got ok=%0b src=%h idx=%0d data=%0d want src=5a idx=7 data=0", ok, s, i, d); end
    endtask

    task automatic test_interleave();
        int sent = 0;
        int guard = 0;
        bit full_q;
        bit ok;
        logic [ID_W-1:0] s; logic [IDX_W-1:0] i; logic [CTR_W-1:0] d;
        full_q = bus.rx_full;
        while (sent < 2000 && guard < 10000) begin
            if (!full_q) begin
                bus.rx_valid = 1'b1;
                bus.rx_srcid = 8'h21;
                bus.rx_arg0  = (sent % 2 == 0) ? 32'd5 : 32'd33;
                bus.rx_arg1  = 32'd1;
                bus.rx_arg2  = 32'd0;
                sent++;
            end else begin
                bus.rx_valid = 1'b0;
            end
            full_q = bus.rx_full;
            step();
            guard++;
        end
        idle(2);
        send(8'h11, 5, 0, 1);
        send(8'h12, 33, 0, 1);
        get_rsp(ok, s, i, d);
        checks++; if (!ok || d !== 32'd1000 || i !== 6'd5) begin errors++; $display("FAIL interleave_idx5: got ok=%0b idx=%0d data=%0d want idx=5 data=1000", ok, i, d); end
        get_rsp(ok, s, i, d);
        checks++; if (!ok || d !== 32'd1000 || i !== 6'd33) begin errors++; $display("FAIL interleave_idx33: got ok=%0b idx=%0d data=%0d want idx=33 data=1000", ok, i, d); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL interleave_drop: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [ID_W-1:0] s; logic [IDX_W-1:0] i; logic [CTR_W-1:0] d;
        for (int k = 0; k < 50; k++) send(8'h31, 1, 2, 0);
        send(8'h32, 1, 0, 1);
        get_rsp(ok, s, i, d);
        checks++; if (!ok || d !== 32'd100) begin errors++; $display("FAIL back_to_back_idx1: got ok=%0b data=%0d want 100", ok, d); end
    endtask

    task automatic test_stall();
        int occ = 0;
        int drops = 0;
        int seen0;
        logic [15:0] d0;
        bit ok;
        logic [ID_W-1:0] s; logic [IDX_W-1:0] i; logic [CTR_W-1:0] d;
        bus.rsp_full = 1'b1;
        send(8'h44, 18, 0, 1);
        idle(4);
        d0 = drop_cnt;
        seen0 = rsp_seen;
        for (int k = 0; k < 12; k++) begin
            if (occ < FIFO_DEPTH) occ++;
            else drops++;
            send(8'h45, 18, 1, 0);
        end
        idle(3);
        checks++; if (drop_cnt - d0 !== 16'(drops)) begin errors++; $display("FAIL stall_drop: got %0d want %0d", drop_cnt - d0, drops); end
        checks++; if (bus.rx_full !== 1'b1) begin errors++; $display("FAIL stall_rx_full: got %0b want 1", bus.rx_full); end
        checks++; if (rsp_seen != seen0) begin errors++; $display("FAIL stall_no_rsp: got %0d responses want %0d", rsp_seen, seen0); end
        bus.rsp_full = 1'b0;
        get_rsp(ok, s, i, d);
        checks++; if (!ok || d !== 32'd0 || s !== 8'h44 || i !== 6'd18) begin errors++; $display("FAIL stall_release_rsp: got ok=%0b src=%h idx=%0d data=%0d want 44/18/0", ok, s, i, d); end
        idle(12);
        send(8'h46, 18, 0, 1);
        get_rsp(ok, s, i, d);
        checks++; if (!ok || d !== 32'(occ)) begin errors++; $display("FAIL stall_accepted: got ok=%0b data=%0d want %0d", ok, d, occ); end
    endtask

    task automatic test_wrap_clear();
        bit ok;
        logic [ID_W-1:0] s; logic [IDX_W-1:0] i; logic [CTR_W-1:0] d;
        send(8'h51, 3, 32'hFFFF_FFFF, 0);
        send(8'h51, 3, 32'd2, 0);
        send(8'h52, 3, 0, 1);
        get_rsp(ok, s, i, d);
        checks++; if (!ok || d !== 32'd1) begin errors++; $display("FAIL wrap_idx3: got ok=%0b data=%0d want 1", ok, d); end
        send(8'h53, 3, 0, 2);
        send(8'h54, 3, 0, 1);
        get_rsp(ok, s, i, d);
        checks++; if (!ok || d !== 32'd0 || s !== 8'h54) begin errors++; $display("FAIL clear_idx3: got ok=%0b src=%h data=%0d want src=54 data=0", ok, s, d); end
    endtask

    task automatic test_bad();
        int seen0;
        seen0 = rsp_seen;
        send(8'h61, 3, 0, 5);
        send(8'h62, 64, 0, 1);
        idle(10);
        checks++; if (bad_cnt !== 16'd2) begin errors++; $display("FAIL bad_cnt: got %0d want 2", bad_cnt); end
        checks++; if (rsp_seen != seen0) begin errors++; $display("FAIL bad_no_rsp: got %0d responses want %0d", rsp_seen, seen0); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit ok;
        logic [ID_W-1:0] s; logic [IDX_W-1:0] i; logic [CTR_W-1:0] d;
        for (int k = 0; k < 5; k++) send(8'h71, 9, 1, 0);
        rst_n = 1'b0;
        send(8'h71, 9, 1, 0);
        bus.rx_valid = 1'b0;
        checks++; if (bus.rx_full !== 1'b1 || bus.rsp_valid !== 1'b0 || init_done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got rx_full=%0b rsp_valid=%0b init_done=%0b want 1/0/0", bus.rx_full, bus.rsp_valid, init_done); end
        checks++; if ({bus.rsp_srcid, bus.rsp_idx, bus.rsp_data} !== '0) begin errors++; $display("FAIL midrst_rsp_fields: got %h/%h/%h want 0", bus.rsp_srcid, bus.rsp_idx, bus.rsp_data); end
        checks++; if (drop_cnt !== 16'd0 || bad_cnt !== 16'd0) begin errors++; $display("FAIL midrst_counts: got drop=%0d bad=%0d want 0/0", drop_cnt, bad_cnt); end
        rst_n = 1'b1;
        wait_init(n);
        checks++; if (n != NUM_CTRS) begin errors++; $display("FAIL midrst_init_cycles: got %0d want %0d", n, NUM_CTRS); end
        idle(5);
        checks++; if (q_data.size() != 0) begin errors++; $display("FAIL midrst_stale_rsp: got %0d queued responses want 0", q_data.size()); end
        send(8'h72, 9, 0, 1);
        get_rsp(ok, s, i, d);
        checks++; if (!ok || d !== 32'd0 || i !== 6'd9) begin errors++; $display("FAIL midrst_read_idx9: got ok=%0b idx=%0d data=%0d want idx=9 data=0", ok, i, d); end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_srcid = '0;
        bus.rx_dstid = '0;
        bus.rx_arg0  = '0;
        bus.rx_arg1  = '0;
        bus.rx_arg2  = '0;
        bus.rsp_full = 1'b0;
        test_reset();
        test_interleave();
        test_back_to_back();
        test_stall();
        test_wrap_clear();
        test_bad();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/counter_server.md
Name: counter_server

Overview:
- Server end of the counters service: accepts active-message requests from kernel clients and applies them to a bank of counters.
- Supported requests: increment, clear, and read-back. Each request carries srcid, dstid and arg0..arg2.
- Datapath: a small input FIFO, then a 2-stage read-modify-write pipeline over a synchronous-read counter RAM with write-to-read bypass, then a registered response port.
- Sits between the request fabric and the client-side response receivers.

Parameters:
- NUM_CTRS, 64, number of counters.
- IDX_W, 6, counter index width; equals log2(NUM_CTRS).
- CTR_W, 32, counter width.
- ARG_W, 32, width of arg0/arg1/arg2.
- ID_W, 8, width of srcid/dstid.
- FIFO_DEPTH, 8, input FIFO entries; minimum 4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- rx_valid  in  1  request present this cycle.
- rx_srcid  in  ID_W  requester id, echoed in the response.
- rx_dstid  in  ID_W  destination id; carried but not decoded.
- rx_arg0  in  ARG_W  counter index.
- rx_arg1  in  ARG_W  increment amount.
- rx_arg2  in  ARG_W  opcode: 0 INC, 1 READ, 2 CLEAR, other values bad.
- rx_full  out  1  backpressure toward clients.
- rsp_valid  out  1  response strobe, one cycle per READ.
- rsp_srcid  out  ID_W  srcid of the READ request.
- rsp_idx  out  IDX_W  index that was read.
- rsp_data  out  CTR_W  counter value.
- rsp_full  in  1  response sink cannot accept.
- init_done  out  1  counter clear sweep complete.
- drop_cnt  out  16  requests dropped on overflow; saturating.
- bad_cnt  out  16  bad-opcode or out-of-range requests; saturating.

Behaviour:
- Reset values: rx_full=1, rsp_valid=0, rsp_srcid/rsp_idx/rsp_data=0, init_done=0, drop_cnt=0, bad_cnt=0.
- Reset also empties the FIFO, invalidates both pipeline stages and restarts the init sweep.
- Reset mid-operation: all in-flight and queued requests are discarded; no responses are issued for them.

Init sweep:
- States: INIT then RUN.
- INIT writes 0 to index 0..NUM_CTRS-1, one index per cycle (64 cycles at default). rx_full is held 1 throughout.
- Requests arriving during INIT are counted in drop_cnt and discarded.
- init_done and the move to RUN occur the cycle after the last index is written.

Backpressure and FIFO:
- Clients register tx one cycle after sampling rx_full, so up to 2 requests may still arrive after rx_full rises.
- In RUN, rx_full = (occupancy >= FIFO_DEPTH-2).
- A push while occupancy == FIFO_DEPTH is discarded and drop_cnt increments.
- Simultaneous push and pop at full: the pop frees a slot, so the push is accepted.

Pipeline:
- S1: pops the FIFO head when S1 is free or advancing and the FIFO is not empty. It issues a RAM read of arg0[IDX_W-1:0].
- S2: RAM data is returned. The operand is the S2 write-back value when the S2 index equals the S1 index in the same cycle (bypass). This makes back-to-back same-index operations exact at full throughput.
- S2 computes and writes back:
  - INC: new = old + arg1[CTR_W-1:0], modulo 2^CTR_W.
  - CLEAR: new = 0.
  - READ: no write.
- Throughput: 1 request per cycle. Latency from pop to write: 2 cycles.
- READ response: rsp_* is registered in the cycle after S2. rsp_data is the value after all earlier requests.
- Stall: when S2 holds a READ and rsp_full=1, S1, S2 and FIFO pop all freeze until rsp_full=0. INC and CLEAR never stall.

Bad requests:
- arg0 >= NUM_CTRS, or opcode > 2: the request passes through the pipeline with no write and no response, and bad_cnt increments once.
- drop_cnt and bad_cnt saturate at 0xFFFF.

Ordering:
- Requests complete in FIFO order.
- No ordering is defined between requests that arrive on the same cycle: there is a single rx port, so this cannot occur.

Test Plan:
- Release reset, drive rx_valid=0 -> init_done rises after exactly 64 RUN-entry cycles, rx_full falls. READ of idx 7 -> rsp_data=0, rsp_srcid echoed.
- Interleave INC idx5 +1 and INC idx33 +1, 1000 each, honouring rx_full with 1-cycle registered tx, then READ both -> 1000 and 1000; drop_cnt=0.
- Back-to-back INC idx1 +2 every cycle, 50 times, then READ idx1 -> 100. This proves the bypass.
- Hold rsp_full=1 with a READ in S2 while a client ignores rx_full and streams 12 INC idx18 +1 -> the FIFO fills, drop_cnt = 12 - (FIFO_DEPTH-2 accepted before full + skid) as scoreboarded; release -> READ matches the accepted count.
- INC idx3 +0xFFFFFFFF, then INC idx3 +2 -> READ 1 (wrap). CLEAR idx3 -> READ 0. Opcode 5 and idx 64 -> bad_cnt=2, no rsp_valid.
- Assert rst_n=0 for 1 cycle mid-stream of INC idx9 -> outputs return to reset values, a fresh 64-cycle sweep runs, and READ idx9 afterward -> 0.
